// File: rtl/systolic_feeder.sv
// Operand feeder for an N1xN2 systolic array: sequences one tile of M steps,
// captures A/B read data and skews lane i by i cycles before the array edge.

module systolic_feeder_skew_lane #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

module systolic_feeder #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N1*DW-1:0] rd_data_A,
    input  logic [N2*DW-1:0] rd_data_B,
    output logic             enable_row_count,
    output logic             clear_acc,
    output logic [N1*DW-1:0] a_out,
    output logic [N1-1:0]    a_valid,
    output logic [N2*DW-1:0] b_out,
    output logic [N2-1:0]    b_valid,
    output logic             busy,
    output logic             tile_done
);

    localparam int MAXN      = (N1 > N2) ? N1 : N2;
    localparam int DRAIN_LEN = MAXN + 2;
    localparam int KW        = $clog2(M + MAXN + 2);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic            cap_valid;
    logic [N1*DW-1:0] cap_a;
    logic [N2*DW-1:0] cap_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            k                <= '0;
            busy             <= 1'b0;
            enable_row_count <= 1'b0;
            clear_acc        <= 1'b0;
            tile_done        <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            clear_acc <= 1'b0;
            case (state)
                IDLE: begin
                    k <= '0;
                    if (start) begin
                        state            <= FEED;
                        busy             <= 1'b1;
                        enable_row_count <= 1'b1;
                        clear_acc        <= 1'b1;
                    end
                end
                FEED: begin
                    if (k == KW'(M - 1)) begin
                        state            <= DRAIN;
                        k                <= '0;
                        enable_row_count <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (k == KW'(DRAIN_LEN - 1)) begin
                        state <= IDLE;
                        k     <= '0;
                        busy  <= 1'b0;
                    end else begin
                        k         <= k + 1'b1;
                        tile_done <= (k == KW'(DRAIN_LEN - 2));
                    end
                end
                default: begin
                    state            <= IDLE;
                    k                <= '0;
                    busy             <= 1'b0;
                    enable_row_count <= 1'b0;
                end
            endcase
        end
    end

    // Read data lags its address by one cycle; the first skew stage is the capture register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= enable_row_count;
        end
    end

    assign cap_a = cap_valid ? rd_data_A : '0;
    assign cap_b = cap_valid ? rd_data_B : '0;

    for (genvar i = 0; i < N1; i++) begin : g_a_lane
        systolic_feeder_skew_lane #(.DEPTH(i + 1), .DW(DW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (cap_valid),
            .in_data   (cap_a[i*DW +: DW]),
            .out_valid (a_valid[i]),
            .out_data  (a_out[i*DW +: DW])
        );
    end

    for (genvar j = 0; j < N2; j++) begin : g_b_lane
        systolic_feeder_skew_lane #(.DEPTH(j + 1), .DW(DW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (cap_valid),
            .in_data   (cap_b[j*DW +: DW]),
            .out_valid (b_valid[j]),
            .out_data  (b_out[j*DW +: DW])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: a 4x4 and a 2x4 instance run side by side
// against expected values derived from the tile timing relative to start.

module tb_systolic_feeder;

    localparam int DW = 8;
    localparam int M  = 8;
    localparam int NONE = -100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rda = '0;
    logic [31:0] rdb = '0;

    logic        en1, clr1, busy1, done1;
    logic [31:0] a_out1, b_out1;
    logic [3:0]  a_vld1, b_vld1;

    logic        en2, clr2, busy2, done2;
    logic [15:0] a_out2;
    logic [1:0]  a_vld2;
    logic [31:0] b_out2;
    logic [3:0]  b_vld2;

    int checks = 0;
    int failures = 0;

    systolic_feeder #(.N1(4), .N2(4), .M(M), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_data_A(rda), .rd_data_B(rdb),
        .enable_row_count(en1), .clear_acc(clr1),
        .a_out(a_out1), .a_valid(a_vld1),
        .b_out(b_out1), .b_valid(b_vld1),
        .busy(busy1), .tile_done(done1)
    );

    systolic_feeder #(.N1(2), .N2(4), .M(M), .DW(DW)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .rd_data_A(rda[15:0]), .rd_data_B(rdb),
        .enable_row_count(en2), .clear_acc(clr2),
        .a_out(a_out2), .a_valid(a_vld2),
        .b_out(b_out2), .b_valid(b_vld2),
        .busy(busy2), .tile_done(done2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // r is the cycle relative to the sampled start (t0); NONE means no tile in flight.
    function automatic logic [3:0] exp_vld(input int r, input int n);
        logic [3:0] v = '0;
        for (int i = 0; i < n; i++)
            v[i] = (r >= 3 + i) && (r <= M + 2 + i);
        return v;
    endfunction

    function automatic logic [31:0] exp_dat(input int r, input int n, input int base);
        logic [31:0] d = '0;
        for (int i = 0; i < n; i++)
            if ((r >= 3 + i) && (r <= M + 2 + i))
                d[i*8 +: 8] = 8'(base + 16 * i + (r - 3 - i));
        return d;
    endfunction

    function automatic logic [31:0] drv_dat(input int r, input int c, input int base);
        logic [31:0] d;
        for (int i = 0; i < 4; i++)
            if ((r >= 2) && (r <= M + 1))
                d[i*8 +: 8] = 8'(base + 16 * i + (r - 2));
            else
                d[i*8 +: 8] = 8'(c * 37 + i * 11 + 1);
        return d;
    endfunction

    task automatic compare_cycle(input int s, input int c, input int r);
        string p;
        p = $sformatf("s%0d c%0d", s, c);
        check({p, " busy"},      busy1,  (r >= 1) && (r <= M + 6));
        check({p, " en_row"},    en1,    (r >= 1) && (r <= M));
        check({p, " clear_acc"}, clr1,   r == 1);
        check({p, " tile_done"}, done1,  r == M + 6);
        check({p, " a_valid"},   a_vld1, exp_vld(r, 4));
        check({p, " a_out"},     a_out1, exp_dat(r, 4, 0));
        check({p, " b_valid"},   b_vld1, exp_vld(r, 4));
        check({p, " b_out"},     b_out1, exp_dat(r, 4, 8'h80));
        check({p, " n2 busy"},   busy2,  (r >= 1) && (r <= M + 6));
        check({p, " n2 en_row"}, en2,    (r >= 1) && (r <= M));
        check({p, " n2 clr"},    clr2,   r == 1);
        check({p, " n2 done"},   done2,  r == M + 6);
        check({p, " n2 a_valid"}, a_vld2, exp_vld(r, 2));
        check({p, " n2 a_out"},  a_out2, exp_dat(r, 2, 0));
        check({p, " n2 b_valid"}, b_vld2, exp_vld(r, 4));
        check({p, " n2 b_out"},  b_out2, exp_dat(r, 4, 8'h80));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int r;
        int t0;

        // Reset held, then released with rd_data toggling and no start
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 rst = (c >= 2);
            start = 1'b0;
            rda = drv_dat(NONE, c, 0);
            rdb = drv_dat(NONE, c, 8'h80);
            @(negedge clk);
            compare_cycle(1, c, NONE);
        end

        // Single tile with lane-tagged data
        for (int c = 0; c < 18; c++) begin
            @(posedge clk);
            #1 start = (c == 0);
            rda = drv_dat(c, c, 0);
            rdb = drv_dat(c, c, 8'h80);
            @(negedge clk);
            compare_cycle(2, c, c);
        end

        // start held high: accepted at 0, 15, 30, 45
        do_reset();
        for (int c = 0; c < 48; c++) begin
            t0 = (c == 0) ? 0 : 15 * ((c - 1) / 15);
            r = c - t0;
            @(posedge clk);
            #1 start = 1'b1;
            rda = drv_dat(r, c, 0);
            rdb = drv_dat(r, c, 8'h80);
            @(negedge clk);
            compare_cycle(3, c, r);
        end

        // Extra start pulses while busy (including the tile_done cycle) are ignored
        do_reset();
        for (int c = 0; c < 21; c++) begin
            @(posedge clk);
            #1 start = (c == 0) || (c == 5) || (c == 14);
            rda = drv_dat(c, c, 0);
            rdb = drv_dat(c, c, 8'h80);
            @(negedge clk);
            compare_cycle(4, c, c);
        end

        // Reset mid-tile at cycle 6, new tile at cycle 10
        do_reset();
        for (int c = 0; c < 29; c++) begin
            r = (c < 6) ? c : ((c < 10) ? NONE : c - 10);
            @(posedge clk);
            #1 rst = !((c == 6) || (c == 7));
            start = (c == 0) || (c == 10);
            rda = drv_dat(r, c, 0);
            rdb = drv_dat(r, c, 8'h80);
            @(negedge clk);
            compare_cycle(5, c, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
